uart_frame_loader: RTL and testbench

Controller between the Uart receiver/transmitter and the Panel framebuffer write port. It parses a framed byte protocol from the host and sequences framebuffer writes. A full-frame load streams one byte per pixel; a fill command writes a single value to every address. Each transaction ends with an ACK or NAK byte on the Uart transmitter, replacing the ad-hoc address counter in the top level.

---
 rtl/uart_frame_loader.sv | 189 ++++++++++++++++++
 tb/tb_uart_frame_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_loader.sv
// Host-protocol controller between the Uart and the panel framebuffer write port.
// Parses SYNC/command framing, sequences pixel-stream and fill writes, and answers each transaction with ACK or NAK.
module uart_frame_loader #(
  parameter int          WIDTH          = 32,
  parameter int          HEIGHT         = 16,
  parameter int          ADDR_W         = 16,
  parameter int          TIMEOUT_CYCLES = 10_000_000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_enable,
  output logic [ADDR_W-1:0] write_address,
  output logic [7:0]        write_value,
  output logic              write_enable,
  output logic              busy,
  output logic [15:0]       frames_loaded
);

  localparam int                N         = WIDTH * HEIGHT;
  localparam int                TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]        CMD_FRAME = 8'h01;
  localparam logic [7:0]        CMD_FILL  = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CMD      = 3'd1,
    S_FRAME    = 3'd2,
    S_FILL_VAL = 3'd3,
    S_FILL     = 3'd4,
    S_RESP     = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic              rx_prev_q;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [7:0]        fill_q, fill_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_en_q, tx_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        val_q, val_d;
  logic              we_q, we_d;
  logic [15:0]       frames_q, frames_d;

  logic accept;
  logic timed;
  logic expired;
  logic last;

  assign accept  = rx_ready & ~rx_prev_q;
  assign timed   = (state_q == S_CMD) || (state_q == S_FRAME) || (state_q == S_FILL_VAL);
  // Expiry wins over a coincident accept: the byte is dropped.
  assign expired = timed && (to_q == TO_LAST);
  assign last    = (cnt_q == LAST_ADDR);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      rx_prev_q <= 1'b0;
      cnt_q     <= '0;
      to_q      <= '0;
      fill_q    <= '0;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      addr_q    <= '0;
      val_q     <= '0;
      we_q      <= 1'b0;
      frames_q  <= '0;
    end else begin
      state_q   <= state_d;
      rx_prev_q <= rx_ready;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      fill_q    <= fill_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      addr_q    <= addr_d;
      val_q     <= val_d;
      we_q      <= we_d;
      frames_q  <= frames_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && (rx_data == SYNC_BYTE)) state_d = S_CMD;
      end
      S_CMD: begin
        if (expired) state_d = S_RESP;
        else if (accept) begin
          if (rx_data == CMD_FRAME)     state_d = S_FRAME;
          else if (rx_data == CMD_FILL) state_d = S_FILL_VAL;
          else                          state_d = S_RESP;
        end
      end
      S_FRAME: begin
        if (expired)             state_d = S_RESP;
        else if (accept && last) state_d = S_RESP;
      end
      S_FILL_VAL: begin
        if (expired)     state_d = S_RESP;
        else if (accept) state_d = S_FILL;
      end
      S_FILL: begin
        if (last) state_d = S_RESP;
      end
      S_RESP: begin
        if (tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    tx_data_d = tx_data_q;
    tx_en_d   = 1'b0;
    addr_d    = addr_q;
    val_d     = val_q;
    we_d      = 1'b0;
    frames_d  = frames_q;
    // Idle-gap counter restarts on every byte and on every state change.
    if (!timed || accept || (state_d != state_q)) to_d = '0;
    else                                          to_d = to_q + TO_W'(1);
    case (state_q)
      S_CMD: begin
        if (expired) tx_data_d = NAK_BYTE;
        else if (accept) begin
          if (rx_data == CMD_FRAME)      cnt_d     = '0;
          else if (rx_data != CMD_FILL)  tx_data_d = NAK_BYTE;
        end
      end
      S_FRAME: begin
        if (expired) tx_data_d = NAK_BYTE;
        else if (accept) begin
          addr_d = cnt_q;
          val_d  = rx_data;
          we_d   = 1'b1;
          cnt_d  = cnt_q + ADDR_W'(1);
          if (last) tx_data_d = ACK_BYTE;
        end
      end
      S_FILL_VAL: begin
        if (expired) tx_data_d = NAK_BYTE;
        else if (accept) begin
          fill_d = rx_data;
          cnt_d  = '0;
        end
      end
      S_FILL: begin
        addr_d = cnt_q;
        val_d  = fill_q;
        we_d   = 1'b1;
        cnt_d  = cnt_q + ADDR_W'(1);
        if (last) tx_data_d = ACK_BYTE;
      end
      S_RESP: begin
        if (tx_ready) begin
          tx_en_d = 1'b1;
          if (tx_data_q == ACK_BYTE) frames_d = frames_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy          = (state_q != S_IDLE);
    tx_data       = tx_data_q;
    tx_enable     = tx_en_q;
    write_address = addr_q;
    write_value   = val_q;
    write_enable  = we_q;
    frames_loaded = frames_q;
  end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader: frame load, fill, bad command, timeout, tx back-pressure and reset abandon.
module tb_uart_frame_loader;

  localparam int ADDR_W = 16;
  localparam int N      = 512;
  localparam int TO     = 1000;
  localparam int MAXW   = 4096;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready = 1'b0;
  logic              tx_ready = 1'b1;
  logic [7:0]        tx_data;
  logic              tx_enable;
  logic [ADDR_W-1:0] write_address;
  logic [7:0]        write_value;
  logic              write_enable;
  logic              busy;
  logic [15:0]       frames_loaded;

  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  int          wr_count = 0;
  int          wr_addr [MAXW];
  int          wr_val  [MAXW];
  int          wr_cyc  [MAXW];
  int          tx_count = 0;
  logic [7:0]  tx_last = 8'h00;
  int          overlap = 0;

  uart_frame_loader #(
    .WIDTH(32), .HEIGHT(16), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO),
    .SYNC_BYTE(8'hA5), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)
  ) dut (
    .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_enable(tx_enable),
    .write_address(write_address), .write_value(write_value),
    .write_enable(write_enable), .busy(busy), .frames_loaded(frames_loaded)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (write_enable) begin
      if (wr_count < MAXW) begin
        wr_addr[wr_count] = int'(write_address);
        wr_val[wr_count]  = int'(write_value);
        wr_cyc[wr_count]  = cyc;
      end
      wr_count = wr_count + 1;
    end
    if (tx_enable) begin
      tx_count = tx_count + 1;
      tx_last  = tx_data;
    end
    if (write_enable && tx_enable) overlap = overlap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
  endtask

  task automatic wait_tx(input string tag, input int budget, output int elapsed);
    int start;
    start   = tx_count;
    elapsed = 0;
    while ((tx_count == start) && (elapsed < budget)) begin
      @(negedge clock);
      elapsed = elapsed + 1;
    end
    chk(tag, 32'(tx_count != start), 32'd1);
  endtask

  task automatic check_run(input string tag, input int base, input int cnt, input int fixed_val);
    int bad;
    bad = 0;
    for (int j = 0; j < cnt; j++) begin
      if (wr_addr[base + j] != j) bad++;
      if (fixed_val < 0) begin
        if (wr_val[base + j] != (j & 255)) bad++;
      end else begin
        if (wr_val[base + j] != fixed_val) bad++;
      end
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    int base;
    int txb;
    int el;
    int bad;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_enable", 32'(tx_enable), 32'd0);
    chk("rst_write_enable", 32'(write_enable), 32'd0);
    chk("rst_frames", 32'(frames_loaded), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    reset_n = 1'b1;

    // Reset in the middle of a frame load
    base = wr_count;
    send_byte(8'hA5);
    send_byte(8'h01);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h80 + i));
    @(negedge clock);
    chk("midframe_writes", 32'(wr_count - base), 32'd10);
    chk("midframe_busy", 32'(busy), 32'd1);
    chk("midframe_last_addr", 32'(write_address), 32'd9);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_addr", 32'(write_address), 32'd0);
    chk("async_rst_value", 32'(write_value), 32'd0);
    chk("async_rst_tx_data", 32'(tx_data), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("after_rst_no_tx", 32'(tx_count), 32'd0);

    // Junk bytes in IDLE, then a full frame
    base = wr_count;
    send_byte(8'h33);
    send_byte(8'h00);
    repeat (2) @(negedge clock);
    chk("junk_no_writes", 32'(wr_count - base), 32'd0);
    chk("junk_not_busy", 32'(busy), 32'd0);
    txb = tx_count;
    send_byte(8'hA5);
    send_byte(8'h01);
    for (int i = 0; i < N; i++) send_byte(8'(i));
    wait_tx("frame_resp_seen", 20, el);
    chk("frame_write_count", 32'(wr_count - base), 32'(N));
    check_run("frame_addr_data", base, N, -1);
    chk("frame_ack", 32'(tx_last), 32'h06);
    chk("frame_frames", 32'(frames_loaded), 32'd1);
    repeat (3) @(negedge clock);
    chk("frame_one_tx", 32'(tx_count - txb), 32'd1);
    chk("frame_idle", 32'(busy), 32'd0);

    // Fill with a stray byte sent during the fill
    base = wr_count;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h3C);
    send_byte(8'h11);
    wait_tx("fill_resp_seen", N + 50, el);
    chk("fill_write_count", 32'(wr_count - base), 32'(N));
    check_run("fill_addr_data", base, N, 8'h3C);
    chk("fill_back_to_back", 32'(wr_cyc[base + N - 1] - wr_cyc[base]), 32'(N - 1));
    chk("fill_ack", 32'(tx_last), 32'h06);
    chk("fill_frames", 32'(frames_loaded), 32'd2);

    // Unknown command
    base = wr_count;
    send_byte(8'hA5);
    send_byte(8'h7F);
    wait_tx("badcmd_resp_seen", 20, el);
    chk("badcmd_nak", 32'(tx_last), 32'h15);
    chk("badcmd_no_writes", 32'(wr_count - base), 32'd0);
    chk("badcmd_frames", 32'(frames_loaded), 32'd2);

    // Timeout part-way through a frame
    base = wr_count;
    send_byte(8'hA5);
    send_byte(8'h01);
    for (int i = 0; i < 100; i++) send_byte(8'(i));
    wait_tx("timeout_resp_seen", TO + 100, el);
    chk("timeout_nak", 32'(tx_last), 32'h15);
    chk("timeout_delay_window", 32'((el >= TO - 10) && (el <= TO + 10)), 32'd1);
    chk("timeout_writes_kept", 32'(wr_count - base), 32'd100);
    chk("timeout_frames", 32'(frames_loaded), 32'd2);

    // Next frame restarts at address 0
    base = wr_count;
    send_byte(8'hA5);
    send_byte(8'h01);
    for (int i = 0; i < N; i++) send_byte(8'(i));
    wait_tx("frame2_resp_seen", 20, el);
    chk("frame2_write_count", 32'(wr_count - base), 32'(N));
    check_run("frame2_addr_data", base, N, -1);
    chk("frame2_ack", 32'(tx_last), 32'h06);
    chk("frame2_frames", 32'(frames_loaded), 32'd3);

    // tx_ready held low at the end of a transaction
    tx_ready = 1'b0;
    txb = tx_count;
    send_byte(8'hA5);
    send_byte(8'h7F);
    repeat (50) @(negedge clock);
    chk("bp_no_tx", 32'(tx_count - txb), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    chk("bp_tx_data", 32'(tx_data), 32'h15);
    tx_ready = 1'b1;
    wait_tx("bp_resp_seen", 10, el);
    repeat (10) @(negedge clock);
    chk("bp_single_pulse", 32'(tx_count - txb), 32'd1);
    chk("bp_idle", 32'(busy), 32'd0);

    // A level held high counts once
    base = wr_count;
    send_byte(8'hA5);
    send_byte(8'h01);
    @(negedge clock);
    rx_data  = 8'h77;
    rx_ready = 1'b1;
    repeat (20) @(negedge clock);
    rx_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("held_single_write", 32'(wr_count - base), 32'd1);
    chk("held_write_value", 32'(write_value), 32'h77);
    wait_tx("held_timeout_seen", TO + 100, el);
    chk("held_timeout_nak", 32'(tx_last), 32'h15);

    bad = overlap;
    chk("we_te_never_overlap", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
